// File: rtl/cfg_discovery_responder_if.sv
// Request/response channel between a debug or boot agent and the
// configuration discovery responder.
// Optional macro CFG_DISCOVERY_PARITY_EN adds the rsp_par_o signal.
interface cfg_discovery_responder_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 8;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_op_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic              rsp_last_o;
`ifdef CFG_DISCOVERY_PARITY_EN
    logic              rsp_par_o;

    modport master (
        output req_valid_i, req_op_i, req_addr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o, rsp_par_o
    );
    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o, rsp_par_o
    );
`else
    modport master (
        output req_valid_i, req_op_i, req_addr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o
    );
    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_last_o
    );
`endif
endinterface

// File: rtl/cfg_discovery_responder.sv
// Read-only configuration discovery responder: answers single-word reads
// describing the elaborated core configuration and dumps PMA region tables
// as base/length beat pairs.
// Optional macro CFG_DISCOVERY_PARITY_EN adds a registered even-parity bit
// (XOR of the response data) on the channel.
module cfg_discovery_responder #(
    parameter int unsigned XLEN         = 64,
    parameter logic [25:0] ISA_MASK     = 26'h014112D,
    parameter int unsigned ICACHE_BYTES = 16384,
    parameter int unsigned ICACHE_ASSOC = 4,
    parameter int unsigned ICACHE_LINE  = 128,
    parameter int unsigned DCACHE_BYTES = 32768,
    parameter int unsigned DCACHE_ASSOC = 8,
    parameter int unsigned DCACHE_LINE  = 128,
    parameter logic [7:0]  DCACHE_TYPE  = 8'd1,
    parameter int unsigned NR_COMMIT    = 2,
    parameter int unsigned NR_SB        = 8,
    parameter int unsigned NR_PMP       = 8,
    parameter int unsigned NR_EXEC      = 3,
    parameter int unsigned NR_CACHED    = 1,
    parameter int unsigned NR_NONIDEM   = 2,
    // Empty tables still get a one-rule-wide port so the vectors stay legal
    localparam int unsigned EXEC_W    = ((NR_EXEC    == 0) ? 1 : NR_EXEC)    * 64,
    localparam int unsigned CACHED_W  = ((NR_CACHED  == 0) ? 1 : NR_CACHED)  * 64,
    localparam int unsigned NONIDEM_W = ((NR_NONIDEM == 0) ? 1 : NR_NONIDEM) * 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cfg_discovery_responder_if.slave bus,
    input  logic [EXEC_W-1:0]    exec_base_i,
    input  logic [EXEC_W-1:0]    exec_len_i,
    input  logic [CACHED_W-1:0]  cached_base_i,
    input  logic [CACHED_W-1:0]  cached_len_i,
    input  logic [NONIDEM_W-1:0] nonidem_base_i,
    input  logic [NONIDEM_W-1:0] nonidem_len_i
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned BEAT_W = 5;

    typedef enum logic [0:0] {IDLE, DUMP} state_t;

    state_t              state_q;
    logic [1:0]          cls_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic                rsp_last_q;

    logic                req_ready_c;
    logic                accept_c;
    logic                fire_c;
    logic [1:0]          lookup_cls_c;
    logic [BEAT_W-1:0]   lookup_beat_c;
    logic [BEAT_W-1:0]   n_rules_c;
    logic [BEAT_W-1:0]   last_idx_c;
    logic [DATA_W-1:0]   table_word_c;
    logic [DATA_W-1:0]   rom_data_c;
    logic                rom_err_c;
    logic                load_c;
    logic                start_dump_c;
    logic [DATA_W-1:0]   ld_data_c;
    logic                ld_err_c;
    logic                ld_last_c;

    // Handshake qualifiers; a new request may land in the cycle the last beat drains
    assign req_ready_c = (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready_i);
    assign accept_c    = bus.req_valid_i && req_ready_c;
    assign fire_c      = rsp_valid_q && bus.rsp_ready_i;

    // Table beat being prepared: beat 0 of the requested class, or the next beat of the dump
    always_comb begin
        lookup_cls_c  = (state_q == IDLE) ? bus.req_addr_i[1:0] : cls_q;
        lookup_beat_c = (state_q == IDLE) ? '0 : beat_q + BEAT_W'(1);
        unique case (lookup_cls_c)
            2'd0:    n_rules_c = BEAT_W'(NR_EXEC);
            2'd1:    n_rules_c = BEAT_W'(NR_CACHED);
            2'd2:    n_rules_c = BEAT_W'(NR_NONIDEM);
            default: n_rules_c = '0;
        endcase
        last_idx_c = BEAT_W'({1'b0, n_rules_c, 1'b0} - 7'd1);
    end

    // Table word select: odd beats carry the length, even beats the base
    always_comb begin
        table_word_c = '0;
        unique case (lookup_cls_c)
            2'd0: for (int k = 0; k < int'(NR_EXEC); k++)
                if (lookup_beat_c[4:1] == 4'(k))
                    table_word_c = lookup_beat_c[0] ? exec_len_i[64*k +: 64]
                                                    : exec_base_i[64*k +: 64];
            2'd1: for (int k = 0; k < int'(NR_CACHED); k++)
                if (lookup_beat_c[4:1] == 4'(k))
                    table_word_c = lookup_beat_c[0] ? cached_len_i[64*k +: 64]
                                                    : cached_base_i[64*k +: 64];
            2'd2: for (int k = 0; k < int'(NR_NONIDEM); k++)
                if (lookup_beat_c[4:1] == 4'(k))
                    table_word_c = lookup_beat_c[0] ? nonidem_len_i[64*k +: 64]
                                                    : nonidem_base_i[64*k +: 64];
            default: table_word_c = '0;
        endcase
    end

    // Single-word discovery map
    always_comb begin
        rom_err_c = 1'b0;
        unique case (bus.req_addr_i)
            8'h00:   rom_data_c = 64'h0000_0000_CA60_0001;
            8'h01:   rom_data_c = DATA_W'(XLEN);
            8'h02:   rom_data_c = DATA_W'(ISA_MASK);
            8'h03:   rom_data_c = {8'h00, 16'(ICACHE_LINE), 8'(ICACHE_ASSOC), 32'(ICACHE_BYTES)};
            8'h04:   rom_data_c = {DCACHE_TYPE, 16'(DCACHE_LINE), 8'(DCACHE_ASSOC), 32'(DCACHE_BYTES)};
            8'h05:   rom_data_c = {16'h0000, 8'(NR_NONIDEM), 8'(NR_CACHED), 8'(NR_EXEC),
                                   8'(NR_PMP), 8'(NR_SB), 8'(NR_COMMIT)};
            default: begin
                rom_data_c = '0;
                rom_err_c  = 1'b1;
            end
        endcase
    end

    // Next response beat: loaded on request acceptance or on each non-final dump handshake
    always_comb begin
        load_c       = 1'b0;
        start_dump_c = 1'b0;
        ld_data_c    = '0;
        ld_err_c     = 1'b0;
        ld_last_c    = 1'b0;
        if ((state_q == IDLE) && accept_c) begin
            load_c = 1'b1;
            if (!bus.req_op_i) begin
                ld_data_c = rom_data_c;
                ld_err_c  = rom_err_c;
                ld_last_c = 1'b1;
            end else if ((lookup_cls_c == 2'd3) || (n_rules_c == '0)) begin
                ld_err_c  = 1'b1;
                ld_last_c = 1'b1;
            end else begin
                start_dump_c = 1'b1;
                ld_data_c    = table_word_c;
            end
        end else if ((state_q == DUMP) && fire_c && !rsp_last_q) begin
            load_c    = 1'b1;
            ld_data_c = table_word_c;
            ld_last_c = (lookup_beat_c == last_idx_c);
        end
    end

    // FSM, beat counter and registered response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cls_q       <= '0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            if (load_c) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= ld_data_c;
                rsp_err_q   <= ld_err_c;
                rsp_last_q  <= ld_last_c;
            end else if (fire_c) begin
                rsp_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: if (start_dump_c) begin
                    state_q <= DUMP;
                    cls_q   <= lookup_cls_c;
                    beat_q  <= '0;
                end
                DUMP: if (fire_c) begin
                    if (rsp_last_q) state_q <= IDLE;
                    else            beat_q  <= lookup_beat_c;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CFG_DISCOVERY_PARITY_EN
    logic rsp_par_q;

    // Parity travels with the data it covers
    always_ff @(posedge clk_i) begin
        if (rst_i)       rsp_par_q <= 1'b0;
        else if (load_c) rsp_par_q <= ^ld_data_c;
    end

    assign bus.rsp_par_o = rsp_par_q;
`endif

    assign bus.req_ready_o = req_ready_c;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_last_o  = rsp_last_q;

endmodule
